mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage engine that consumes the EX/MEM pipeline register and produces the MEM/WB register.
//  Drives a req/ack data memory and resolves branches.
//  Stalls the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) while a load/store is in flight.
//  Sits between the EX/MEM register and the WB mux.
// PARAMETERS
//  MAX_WAIT  255  ACCESS cycles without dm_ack before watchdog abort (1..255)
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  ex_RegWrite   in   1   EX/MEM: register write enable
//  ex_MemtoReg   in   2   EX/MEM: WB mux select (00 ALU, 01 mem, 10 pc+4)
//  ex_MemRead    in   1   EX/MEM: load
//  ex_MemWrite   in   1   EX/MEM: store
//  ex_PCsrc      in   1   EX/MEM: branch instruction
//  ex_zero       in   1   EX/MEM: ALU zero flag
//  ex_w          in   5   EX/MEM: destination register
//  ex_pcp4       in   32  EX/MEM: pc+4
//  ex_pc         in   32  EX/MEM: branch target
//  ex_O          in   32  EX/MEM: ALU result / memory address
//  ex_rdata2     in   32  EX/MEM: store data
//  dm_req        out  1   memory request, held until dm_ack
//  dm_we         out  1   1 = write, 0 = read
//  dm_addr       out  32  word-aligned byte address
//  dm_wdata      out  32  store data
//  dm_ack        in   1   memory completion, one-cycle pulse
//  dm_rdata      in   32  load data, valid with dm_ack
//  stall         out  1   freeze upstream stages and EX/MEM
//  branch_taken  out  1   redirect PC to branch_target this cycle
//  branch_target out  32  = ex_pc
//  wb_RegWrite   out  1   MEM/WB register field
//  wb_MemtoReg   out  2   MEM/WB register field
//  wb_w          out  5   MEM/WB register field
//  wb_rdata      out  32  MEM/WB register field
//  wb_O          out  32  MEM/WB register field
//  wb_pcp4       out  32  MEM/WB register field
//  mem_err       out  1   sticky: watchdog timeout or misaligned access
// BEHAVIOUR
//  Reset (rst=1 at posedge) clears state, even mid-access:
//   - FSM to IDLE; dm_req/dm_we = 0; dm_addr/dm_wdata = 0.
//   - All wb_* = 0; mem_err = 0; wait counter and rdata_hold = 0.
//  Definitions: access = ex_MemRead | ex_MemWrite. If both are set, the access is a write.
//  FSM states: IDLE, ACCESS, DONE.
//   IDLE, no access:
//    - stall = 0; MEM/WB loads ex_* at the edge (1-cycle latency); wb_rdata = 0.
//   IDLE, access, ex_O[1:0] != 0 (misaligned):
//    - Set mem_err; issue no request; rdata_hold = 0; go to DONE.
//    - stall = 1 this cycle.
//   IDLE, access, aligned:
//    - Register dm_addr = ex_O, dm_wdata = ex_rdata2, dm_we = write.
//    - Go to ACCESS; stall = 1 this cycle.
//   ACCESS:
//    - dm_req = 1 with dm_addr/dm_we/dm_wdata held stable; stall = 1; counter increments.
//    - On dm_ack: capture dm_rdata into rdata_hold; drop dm_req next cycle; go to DONE.
//    - If counter reaches MAX_WAIT without ack: set mem_err, rdata_hold = 0, drop dm_req, go to DONE.
//    - dm_ack outside ACCESS is ignored.
//   DONE:
//    - stall = 0; MEM/WB loads ex_* with wb_rdata = rdata_hold; go to IDLE.
//    - DONE never re-issues the access; EX/MEM advances at this edge.
//  Bubbles: any edge with stall = 1 loads wb_RegWrite = 0; all other wb_* hold.
//  Latency: load/store with ack in its first ACCESS cycle = 3 cycles (2 stall cycles).
//  Branch: branch_taken = ex_PCsrc & ex_zero & (state == IDLE) & ~access; combinational.
//  mem_err stays set until rst; the pipeline continues after an error.
// TESTING
//  1. ALU op: ex_RegWrite=1, ex_w=5, ex_O=0x1234, no access
//     -> next cycle wb_RegWrite=1, wb_w=5, wb_O=0x1234, stall never asserted.
//  2. Load ex_O=0x40, dm_ack on first ACCESS cycle with dm_rdata=0xDEADBEEF
//     -> stall high 2 cycles, dm_req 1 cycle, wb_rdata=0xDEADBEEF after DONE.
//  3. Store ex_O=0x80, ex_rdata2=0xA5A5A5A5, ack delayed 4 cycles
//     -> dm_we=1, dm_addr/dm_wdata stable all 5 req cycles, wb_RegWrite=0 each stall cycle.
//  4. MAX_WAIT=8, load, no ack -> dm_req drops after 8 cycles, mem_err=1, wb_rdata=0, pipeline resumes.
//  5. Load ex_O=0x42 (misaligned) -> no dm_req, mem_err=1, stall exactly 1 cycle.
//  6. rst in 2nd ACCESS cycle -> next cycle dm_req=0, stall=0, wb_*=0; ex_PCsrc=1, ex_zero=1 -> branch_taken=1.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: drives a req/ack data memory, resolves branches and
// produces the MEM/WB register, stalling upstream while an access is in flight.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_RegWrite,
    input  logic [1:0]  ex_MemtoReg,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic        ex_PCsrc,
    input  logic        ex_zero,
    input  logic [4:0]  ex_w,
    input  logic [31:0] ex_pcp4,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_O,
    input  logic [31:0] ex_rdata2,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        wb_RegWrite,
    output logic [1:0]  wb_MemtoReg,
    output logic [4:0]  wb_w,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_O,
    output logic [31:0] wb_pcp4,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] LastCnt = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        wb_rw_q, wb_rw_d;
    logic [1:0]  wb_mtr_q, wb_mtr_d;
    logic [4:0]  wb_w_q, wb_w_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_o_q, wb_o_d;
    logic [31:0] wb_pcp4_q, wb_pcp4_d;

    logic access;
    logic misaligned;

    assign access     = ex_MemRead | ex_MemWrite;
    assign misaligned = |ex_O[1:0];

    assign stall = ((state_q == IDLE) && access) || (state_q == ACCESS);

    assign branch_taken  = ex_PCsrc & ex_zero & (state_q == IDLE) & ~access;
    assign branch_target = ex_pc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (access && misaligned) begin
                    err_d   = 1'b1;
                    hold_d  = '0;
                    state_d = DONE;
                end else if (access) begin
                    addr_d  = ex_O;
                    wdata_d = ex_rdata2;
                    we_d    = ex_MemWrite;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (dm_ack) begin
                    hold_d  = dm_rdata;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == LastCnt) begin
                    // watchdog: give up and let the pipeline move on
                    err_d   = 1'b1;
                    hold_d  = '0;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wb_rw_d    = wb_rw_q;
        wb_mtr_d   = wb_mtr_q;
        wb_w_d     = wb_w_q;
        wb_rdata_d = wb_rdata_q;
        wb_o_d     = wb_o_q;
        wb_pcp4_d  = wb_pcp4_q;
        if (stall) begin
            wb_rw_d = 1'b0;
        end else begin
            wb_rw_d    = ex_RegWrite;
            wb_mtr_d   = ex_MemtoReg;
            wb_w_d     = ex_w;
            wb_o_d     = ex_O;
            wb_pcp4_d  = ex_pcp4;
            wb_rdata_d = (state_q == DONE) ? hold_q : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_mtr_q   <= '0;
            wb_w_q     <= '0;
            wb_rdata_q <= '0;
            wb_o_q     <= '0;
            wb_pcp4_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            wb_rw_q    <= wb_rw_d;
            wb_mtr_q   <= wb_mtr_d;
            wb_w_q     <= wb_w_d;
            wb_rdata_q <= wb_rdata_d;
            wb_o_q     <= wb_o_d;
            wb_pcp4_q  <= wb_pcp4_d;
        end
    end

    assign dm_req      = req_q;
    assign dm_we       = we_q;
    assign dm_addr     = addr_q;
    assign dm_wdata    = wdata_q;
    assign mem_err     = err_q;
    assign wb_RegWrite = wb_rw_q;
    assign wb_MemtoReg = wb_mtr_q;
    assign wb_w        = wb_w_q;
    assign wb_rdata    = wb_rdata_q;
    assign wb_O        = wb_o_q;
    assign wb_pcp4     = wb_pcp4_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model predicts
// every output each cycle, plus literal expectations per scenario.
module tb_mem_access_stage;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_RegWrite;
    logic [1:0]  ex_MemtoReg;
    logic        ex_MemRead;
    logic        ex_MemWrite;
    logic        ex_PCsrc;
    logic        ex_zero;
    logic [4:0]  ex_w;
    logic [31:0] ex_pcp4;
    logic [31:0] ex_pc;
    logic [31:0] ex_O;
    logic [31:0] ex_rdata2;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        wb_RegWrite;
    logic [1:0]  wb_MemtoReg;
    logic [4:0]  wb_w;
    logic [31:0] wb_rdata;
    logic [31:0] wb_O;
    logic [31:0] wb_pcp4;
    logic        mem_err;

    always #5 clk = ~clk;

    mem_access_stage #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_PCsrc(ex_PCsrc), .ex_zero(ex_zero), .ex_w(ex_w),
        .ex_pcp4(ex_pcp4), .ex_pc(ex_pc), .ex_O(ex_O),
        .ex_rdata2(ex_rdata2),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_w(wb_w), .wb_rdata(wb_rdata), .wb_O(wb_O),
        .wb_pcp4(wb_pcp4), .mem_err(mem_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory responder: ack after ack_delay request cycles (-1 = never)
    int   ack_delay = -1;
    int   rq_seen = 0;
    logic stray = 1'b0;

    always @(posedge clk) begin
        #1;
        if (dm_req) begin
            dm_ack = (rq_seen == ack_delay) | stray;
            rq_seen++;
        end else begin
            dm_ack = stray;
            rq_seen = 0;
        end
    end

    // model: an instruction either passes straight through, or occupies
    // the stage for an access (busy) followed by one retire cycle (ready)
    bit          m_busy, m_ready, m_err, m_we;
    int          m_wait;
    logic [31:0] m_hold, m_addr, m_wdata;
    logic        e_rw;
    logic [1:0]  e_mtr;
    logic [4:0]  e_w;
    logic [31:0] e_rdata, e_o, e_pcp4;

    task automatic m_retire(input logic [31:0] rd);
        e_rw = ex_RegWrite;
        e_mtr = ex_MemtoReg;
        e_w = ex_w;
        e_o = ex_O;
        e_pcp4 = ex_pcp4;
        e_rdata = rd;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_ready = 0; m_err = 0; m_we = 0;
            m_wait = 0; m_hold = 0; m_addr = 0; m_wdata = 0;
            e_rw = 0; e_mtr = 0; e_w = 0;
            e_rdata = 0; e_o = 0; e_pcp4 = 0;
        end else if (m_ready) begin
            m_retire(m_hold);
            m_ready = 0;
        end else if (m_busy) begin
            e_rw = 0;
            m_wait++;
            if (dm_ack) begin
                m_hold = dm_rdata;
                m_busy = 0;
                m_ready = 1;
            end else if (m_wait == MAXW) begin
                m_err = 1;
                m_hold = 0;
                m_busy = 0;
                m_ready = 1;
            end
        end else if (ex_MemRead | ex_MemWrite) begin
            e_rw = 0;
            if (ex_O % 4 != 0) begin
                m_err = 1;
                m_hold = 0;
                m_ready = 1;
            end else begin
                m_busy = 1;
                m_wait = 0;
                m_addr = ex_O;
                m_wdata = ex_rdata2;
                m_we = ex_MemWrite;
            end
        end else begin
            m_retire(32'd0);
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic acc, free;
            acc  = ex_MemRead | ex_MemWrite;
            free = !m_busy && !m_ready;
            chk("stall", stall, m_busy | (free & acc));
            chk("branch_taken", branch_taken,
                ex_PCsrc & ex_zero & free & !acc);
            chk("branch_target", branch_target, ex_pc);
            chk("dm_req", dm_req, m_busy);
            chk("dm_we", dm_we, m_we);
            chk("dm_addr", dm_addr, m_addr);
            chk("dm_wdata", dm_wdata, m_wdata);
            chk("mem_err", mem_err, m_err);
            chk("wb_RegWrite", wb_RegWrite, e_rw);
            chk("wb_MemtoReg", wb_MemtoReg, e_mtr);
            chk("wb_w", wb_w, e_w);
            chk("wb_rdata", wb_rdata, e_rdata);
            chk("wb_O", wb_O, e_o);
            chk("wb_pcp4", wb_pcp4, e_pcp4);
        end
    end

    task automatic set_ex(input logic rw, input logic [1:0] mtr,
                          input logic mr, input logic mw,
                          input logic pcs, input logic z,
                          input logic [4:0] w, input logic [31:0] o,
                          input logic [31:0] rd2);
        ex_RegWrite = rw;
        ex_MemtoReg = mtr;
        ex_MemRead = mr;
        ex_MemWrite = mw;
        ex_PCsrc = pcs;
        ex_zero = z;
        ex_w = w;
        ex_O = o;
        ex_rdata2 = rd2;
        ex_pcp4 = o + 32'h1000;
        ex_pc = o + 32'h2000;
    endtask

    // hold the instruction until the stage releases it, then retire it
    task automatic issue(input logic rw, input logic [1:0] mtr,
                         input logic mr, input logic mw,
                         input logic pcs, input logic z,
                         input logic [4:0] w, input logic [31:0] o,
                         input logic [31:0] rd2,
                         output int stalls, output int reqs);
        set_ex(rw, mtr, mr, mw, pcs, z, w, o, rd2);
        stalls = 0;
        reqs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dm_req) reqs++;
            if (!stall) break;
            stalls++;
        end
        if (stall) chk("issue_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        set_ex(0, 2'b00, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
    endtask

    int st, rq;

    initial begin
        rst = 1'b1;
        dm_ack = 1'b0;
        dm_rdata = 32'd0;
        set_ex(0, 2'b00, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        chk_en = 1;
        @(posedge clk);
        #1;
        chk("rst_dm_req", dm_req, 32'd0);
        chk("rst_wb_O", wb_O, 32'd0);
        chk("rst_mem_err", mem_err, 32'd0);
        rst = 1'b0;

        // ALU op with a stray ack while idle
        stray = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 2'b00, 0, 0, 1, 1, 5'd5, 32'h1234, 32'h0, st, rq);
        stray = 1'b0;
        chk("t1_wb_RegWrite", wb_RegWrite, 32'd1);
        chk("t1_wb_w", wb_w, 32'd5);
        chk("t1_wb_O", wb_O, 32'h1234);
        chk("t1_stalls", st, 32'd0);
        @(posedge clk);
        #1;

        // load, ack in first access cycle
        ack_delay = 0;
        dm_rdata = 32'hDEADBEEF;
        issue(1, 2'b01, 1, 0, 1, 1, 5'd7, 32'h40, 32'h0, st, rq);
        chk("t2_stalls", st, 32'd2);
        chk("t2_reqs", rq, 32'd1);
        chk("t2_wb_rdata", wb_rdata, 32'hDEADBEEF);
        chk("t2_wb_w", wb_w, 32'd7);

        // store, ack after 4 extra request cycles
        ack_delay = 4;
        dm_rdata = 32'h11111111;
        issue(0, 2'b00, 0, 1, 0, 0, 5'd0, 32'h80, 32'hA5A5A5A5, st, rq);
        chk("t3_stalls", st, 32'd6);
        chk("t3_reqs", rq, 32'd5);
        chk("t3_dm_we", dm_we, 32'd1);
        chk("t3_dm_wdata", dm_wdata, 32'hA5A5A5A5);
        chk("t3_wb_RegWrite", wb_RegWrite, 32'd0);

        // misaligned load
        ack_delay = 0;
        chk("t5_err_before", mem_err, 32'd0);
        issue(1, 2'b01, 1, 0, 0, 0, 5'd4, 32'h42, 32'h0, st, rq);
        chk("t5_stalls", st, 32'd1);
        chk("t5_reqs", rq, 32'd0);
        chk("t5_mem_err", mem_err, 32'd1);
        chk("t5_wb_rdata", wb_rdata, 32'd0);
        issue(1, 2'b00, 0, 0, 0, 0, 5'd3, 32'h55, 32'h0, st, rq);
        chk("t5_resume_wb_O", wb_O, 32'h55);

        // reset in second access cycle
        ack_delay = -1;
        set_ex(1, 2'b01, 1, 0, 0, 0, 5'd2, 32'h100, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t6_req_mid", dm_req, 32'd1);
        rst = 1'b1;
        set_ex(0, 2'b00, 0, 0, 1, 1, 5'd0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_dm_req", dm_req, 32'd0);
        chk("t6_stall", stall, 32'd0);
        chk("t6_wb_rdata", wb_rdata, 32'd0);
        chk("t6_mem_err", mem_err, 32'd0);
        chk("t6_branch_taken", branch_taken, 32'd1);
        chk("t6_branch_target", branch_target, 32'h2000);

        // watchdog timeout
        issue(1, 2'b01, 1, 0, 0, 0, 5'd9, 32'h200, 32'h0, st, rq);
        chk("t4_reqs", rq, 32'd8);
        chk("t4_stalls", st, 32'd9);
        chk("t4_mem_err", mem_err, 32'd1);
        chk("t4_wb_rdata", wb_rdata, 32'd0);
        chk("t4_wb_RegWrite", wb_RegWrite, 32'd1);
        issue(1, 2'b00, 0, 0, 0, 0, 5'd6, 32'h77, 32'h0, st, rq);
        chk("t4_resume_wb_O", wb_O, 32'h77);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
